// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the Rx top level (master) and the receive controller (slave).
interface uart_rx_ctrl_if;
    logic baud_tick;
    logic rx_in;
    logic sipo_clr;
    logic sipo_en;
    logic sipo_rx;
    logic rx_busy;
    logic rx_done;
    logic frame_err;
    logic parity_err;

    modport master (
        output baud_tick, rx_in,
        input  sipo_clr, sipo_en, sipo_rx, rx_busy, rx_done, frame_err, parity_err
    );

    modport slave (
        input  baud_tick, rx_in,
        output sipo_clr, sipo_en, sipo_rx, rx_busy, rx_done, frame_err, parity_err
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, mid-cell sampling, shift-stage control, stop/parity check.
// Optional parity bit between data and stop is enabled by defining RX_PARITY_EN.
module uart_rx_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic         clk,
    input  logic         rx_rst_n,
    uart_rx_ctrl_if.slave bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 1 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_rx_ctrl: unsupported parameter values");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tick_cnt, tick_nxt;
    logic [BW-1:0] bit_cnt, bit_nxt;
    logic          rx_meta, rx_s;
    logic          clr_pulse, clr_nxt;
    logic          en_pulse, en_nxt;
    logic          rx_bit, rx_bit_nxt;
    logic          busy, busy_nxt;
    logic          done_pulse, done_nxt;
    logic          ferr_pulse, ferr_nxt;
`ifdef RX_PARITY_EN
    logic          acc, acc_nxt;
    logic          mismatch, mismatch_nxt;
    logic          perr_pulse, perr_nxt;
`endif

    always_comb begin
        state_nxt  = state;
        tick_nxt   = tick_cnt;
        bit_nxt    = bit_cnt;
        clr_nxt    = 1'b0;
        en_nxt     = 1'b0;
        rx_bit_nxt = rx_bit;
        done_nxt   = 1'b0;
        ferr_nxt   = 1'b0;
`ifdef RX_PARITY_EN
        acc_nxt      = acc;
        mismatch_nxt = mismatch;
        perr_nxt     = 1'b0;
`endif
        if (bus.baud_tick) begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) state_nxt = S_START;
                end
                S_START: begin
                    if (tick_cnt == TICK_MID) begin
                        if (!rx_s) begin
                            state_nxt = S_DATA;
                            clr_nxt   = 1'b1;
                            bit_nxt   = '0;
`ifdef RX_PARITY_EN
                            acc_nxt   = 1'b0;
`endif
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        en_nxt     = 1'b1;
                        rx_bit_nxt = rx_s;
                        bit_nxt    = bit_cnt + 1'b1;
                        tick_nxt   = '0;
`ifdef RX_PARITY_EN
                        acc_nxt    = acc ^ rx_s;
                        if (bit_cnt == BIT_LAST) state_nxt = S_PARITY;
`else
                        if (bit_cnt == BIT_LAST) state_nxt = S_STOP;
`endif
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
`ifdef RX_PARITY_EN
                S_PARITY: begin
                    if (tick_cnt == TICK_LAST) begin
                        mismatch_nxt = acc ^ rx_s ^ (PARITY_ODD != 0);
                        state_nxt    = S_STOP;
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        if (rx_s) begin
                            done_nxt  = 1'b1;
`ifdef RX_PARITY_EN
                            perr_nxt  = mismatch;
`endif
                            state_nxt = S_IDLE;
                        end else begin
                            ferr_nxt  = 1'b1;
                            state_nxt = S_BREAK;
                        end
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
        // Every state change restarts the cell timing.
        if (state_nxt != state) tick_nxt = '0;
        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rx_rst_n) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            state      <= S_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            clr_pulse  <= 1'b0;
            en_pulse   <= 1'b0;
            rx_bit     <= 1'b1;
            busy       <= 1'b0;
            done_pulse <= 1'b0;
            ferr_pulse <= 1'b0;
`ifdef RX_PARITY_EN
            perr_pulse <= 1'b0;
`endif
        end else begin
            rx_meta    <= bus.rx_in;
            rx_s       <= rx_meta;
            state      <= state_nxt;
            tick_cnt   <= tick_nxt;
            bit_cnt    <= bit_nxt;
            clr_pulse  <= clr_nxt;
            en_pulse   <= en_nxt;
            rx_bit     <= rx_bit_nxt;
            busy       <= busy_nxt;
            done_pulse <= done_nxt;
            ferr_pulse <= ferr_nxt;
`ifdef RX_PARITY_EN
            perr_pulse <= perr_nxt;
`endif
        end
    end

`ifdef RX_PARITY_EN
    // Parity datapath needs no reset: cleared on start accept, latched before use at stop.
    always_ff @(posedge clk) begin
        acc      <= acc_nxt;
        mismatch <= mismatch_nxt;
    end
    assign bus.parity_err = perr_pulse;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.sipo_clr  = clr_pulse;
    assign bus.sipo_en   = en_pulse;
    assign bus.sipo_rx   = rx_bit;
    assign bus.rx_busy   = busy;
    assign bus.rx_done   = done_pulse;
    assign bus.frame_err = ferr_pulse;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: baud_tick every 4 clk, OVERSAMPLE 16, 8 data bits.
module tb_uart_rx_ctrl;
    localparam int OS   = 16;
    localparam int DIV  = 4;
    localparam int CELL = OS * DIV;
`ifdef RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    // Detect tick to stop-sample tick: half cell + data cells + parity + stop cell.
    localparam int BUSY_SPAN = (OS / 2 + (8 + PBITS + 1) * OS) * DIV;

    logic clk = 1'b0;
    logic rx_rst_n = 1'b0;

    uart_rx_ctrl_if bus();

    uart_rx_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_ODD(0)) dut (
        .clk      (clk),
        .rx_rst_n (rx_rst_n),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int clr_cnt = 0, en_cnt = 0, done_cnt = 0, ferr_cnt = 0;
    int perr_cnt = 0, perr_done_cnt = 0, busy_cyc = 0, overlap_cnt = 0;
    logic [7:0] cap = 8'h00;
    int c0, e0, d0, f0, p0, b0;

    always @(negedge clk) begin
        if (bus.sipo_clr) clr_cnt <= clr_cnt + 1;
        if (bus.sipo_en) begin
            en_cnt <= en_cnt + 1;
            cap    <= {bus.sipo_rx, cap[7:1]};
        end
        if (bus.rx_done)   done_cnt <= done_cnt + 1;
        if (bus.frame_err) ferr_cnt <= ferr_cnt + 1;
        if (bus.parity_err) begin
            perr_cnt <= perr_cnt + 1;
            if (bus.rx_done) perr_done_cnt <= perr_done_cnt + 1;
        end
        if (bus.rx_busy) busy_cyc <= busy_cyc + 1;
        if (int'(bus.sipo_clr) + int'(bus.sipo_en) + int'(bus.rx_done | bus.frame_err) > 1)
            overlap_cnt <= overlap_cnt + 1;
    end

    initial begin
        bus.baud_tick = 1'b0;
        forever begin
            repeat (DIV - 1) @(negedge clk);
            bus.baud_tick = 1'b1;
            @(negedge clk);
            bus.baud_tick = 1'b0;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic send_bit(input logic b);
        bus.rx_in = b;
        repeat (CELL) @(negedge clk);
    endtask

    task automatic send_data(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_bit(1'b0);
        send_data(d);
`ifdef RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_bit);
    endtask

    task automatic idle(input int cells);
        bus.rx_in = 1'b1;
        repeat (cells * CELL) @(negedge clk);
    endtask

    task automatic snap();
        c0 = clr_cnt; e0 = en_cnt; d0 = done_cnt; f0 = ferr_cnt; p0 = perr_done_cnt; b0 = busy_cyc;
    endtask

    initial begin
        bus.rx_in = 1'b1;
        rx_rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_clr",   bus.sipo_clr,   0);
        check_val("rst_en",    bus.sipo_en,    0);
        check_val("rst_rx",    bus.sipo_rx,    1);
        check_val("rst_busy",  bus.rx_busy,    0);
        check_val("rst_done",  bus.rx_done,    0);
        check_val("rst_ferr",  bus.frame_err,  0);
        check_val("rst_perr",  bus.parity_err, 0);
        rx_rst_n = 1'b1;
        idle(2);

        // Plain frame 0xA5
        snap();
        send_frame(8'hA5, 1'b1);
        idle(1);
        check_val("a5_clr",  clr_cnt - c0, 1);
        check_val("a5_en",   en_cnt - e0,  8);
        check_val("a5_data", cap,          8'hA5);
        check_val("a5_done", done_cnt - d0, 1);
        check_val("a5_ferr", ferr_cnt - f0, 0);
        check_val("a5_busy_span", busy_cyc - b0, BUSY_SPAN);
        check_val("a5_busy_end",  bus.rx_busy, 0);

        // False start: 3 ticks low
        snap();
        bus.rx_in = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        idle(2);
        check_val("fs_clr",  clr_cnt - c0, 0);
        check_val("fs_en",   en_cnt - e0,  0);
        check_val("fs_busy_seen", (busy_cyc - b0) > 0, 1);
        check_val("fs_busy_end",  bus.rx_busy, 0);

        // Stop bit low, then break held for 40 ticks
        snap();
        send_bit(1'b0);
        send_data(8'h3C);
`ifdef RX_PARITY_EN
        send_bit(1'b0);
`endif
        send_bit(1'b0);
        repeat (40 * DIV) @(negedge clk);
        check_val("brk_ferr", ferr_cnt - f0, 1);
        check_val("brk_done", done_cnt - d0, 0);
        check_val("brk_clr",  clr_cnt - c0,  1);
        check_val("brk_busy", bus.rx_busy,   1);
        idle(1);
        check_val("brk_busy_end", bus.rx_busy, 0);
        snap();
        send_frame(8'h55, 1'b1);
        idle(1);
        check_val("post_brk_data", cap, 8'h55);
        check_val("post_brk_done", done_cnt - d0, 1);
        check_val("post_brk_en",   en_cnt - e0,   8);

`ifdef RX_PARITY_EN
        snap();
        send_bit(1'b0); send_data(8'hA5); send_bit(1'b0); send_bit(1'b1);
        idle(1);
        check_val("par_ok_done", done_cnt - d0, 1);
        check_val("par_ok_perr", perr_done_cnt - p0, 0);
        snap();
        send_bit(1'b0); send_data(8'hA5); send_bit(1'b1); send_bit(1'b1);
        idle(1);
        check_val("par_bad_done", done_cnt - d0, 1);
        check_val("par_bad_perr", perr_done_cnt - p0, 1);
`endif

        // Reset after the 4th data bit
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(8'hA5 >> i);
        check_val("mid_en4", en_cnt - e0, 4);
        bus.rx_in = 1'b1;
        rx_rst_n  = 1'b0;
        @(negedge clk);
        rx_rst_n  = 1'b1;
        check_val("mid_rst_busy", bus.rx_busy, 0);
        check_val("mid_rst_en",   bus.sipo_en, 0);
        idle(12);
        check_val("mid_no_done", done_cnt - d0, 0);
        check_val("mid_no_en",   en_cnt - e0,   4);
        snap();
        send_frame(8'hC3, 1'b1);
        idle(1);
        check_val("c3_en",   en_cnt - e0,   8);
        check_val("c3_done", done_cnt - d0, 1);
        check_val("c3_data", cap, 8'hC3);

        // Back-to-back frames
        snap();
        send_frame(8'h01, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(1);
        check_val("b2b_done", done_cnt - d0, 2);
        check_val("b2b_en",   en_cnt - e0,  16);
        check_val("b2b_ferr", ferr_cnt - f0, 0);
        check_val("b2b_data", cap, 8'hFF);

        check_val("pulse_overlap", overlap_cnt, 0);
        check_val("perr_alone", perr_cnt - perr_done_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
